// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM encoding and
// instruction field positions.
package alu_issue_ctrl_pkg;

    localparam int INSTR_W = 16;
    localparam int RF_AW   = 4;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_BZ   = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b1010;
    localparam logic [3:0] OP_SUBI = 4'b1011;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RD_HI = 11;
    localparam int RD_LO = 8;
    localparam int RS_HI = 7;
    localparam int RS_LO = 4;
    localparam int RT_HI = 3;
    localparam int RT_LO = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_BR   = 2'd3
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 16-entry architectural register file: two operand reads, one debug read,
// one synchronous write; r0 is hardwired to zero.
module alu_regfile #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ra_addr,
    input  logic [3:0]        rb_addr,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [3:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [16];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != 4'd0)) begin
            mem[wa] <= wd;
        end
    end

    // r0 is forced on the read side so it stays zero regardless of storage.
    assign ra_data  = (ra_addr  == 4'd0) ? '0 : mem[ra_addr];
    assign rb_data  = (rb_addr  == 4'd0) ? '0 : mem[rb_addr];
    assign dbg_data = (dbg_addr == 4'd0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts instructions, issues registered operands to the
// ALU, writes back the ALU result and resolves branch-on-zero.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8,
    parameter int IMM_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] alu_imm,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              wb_valid,
    output logic              pc_redirect,
    output logic [PC_W-1:0]   pc_target,
    output logic              zero_flag,
    output logic              illegal_op,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    // Handshake: an instruction transfers on a posedge where instr_valid and
    // instr_ready are both high; instr is ignored whenever instr_ready is low.
    state_t state, state_nxt;

    logic [3:0]        op, rd, rs, rt;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic              accept;
    logic              issue, br_latch, br_fire, wb_en, illegal_set;
    logic [3:0]        rd_q;
    logic [PC_W-1:0]   tgt_q;

    assign op       = instr[OP_HI:OP_LO];
    assign rd       = instr[RD_HI:RD_LO];
    assign rs       = instr[RS_HI:RS_LO];
    assign rt       = instr[RT_HI:RT_LO];
    assign imm      = instr[IMM_W-1:0];
    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    assign instr_ready = (state == S_IDLE) & ~rst;
    assign accept      = instr_valid & instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        br_latch    = 1'b0;
        br_fire     = 1'b0;
        wb_en       = 1'b0;
        illegal_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_alu_op(op)) begin
                        state_nxt = S_EXEC;
                        issue     = 1'b1;
                    end else if (op == OP_BZ) begin
                        state_nxt = S_BR;
                        br_latch  = 1'b1;
                    end else begin
                        illegal_set = 1'b1;
                    end
                end
            end
            S_EXEC: state_nxt = S_WB;
            S_WB: begin
                state_nxt = S_IDLE;
                wb_en     = 1'b1;
            end
            S_BR: begin
                state_nxt = S_IDLE;
                br_fire   = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The ALU sees a non-zero opcode for exactly the EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_opcode  <= OP_NOP;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_imm     <= '0;
            rd_q        <= '0;
            tgt_q       <= '0;
            wb_valid    <= 1'b0;
            pc_redirect <= 1'b0;
            pc_target   <= '0;
            zero_flag   <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            alu_opcode  <= issue ? op : OP_NOP;
            wb_valid    <= wb_en;
            pc_redirect <= br_fire & zero_flag;
            if (issue) begin
                alu_a   <= rs_data;
                alu_b   <= rt_data;
                alu_imm <= imm_sext;
                rd_q    <= rd;
            end
            if (br_latch) begin
                tgt_q <= instr[PC_W-1:0];
            end
            if (br_fire) begin
                pc_target <= tgt_q;
            end
            if (wb_en) begin
                zero_flag <= alu_zero;
            end
            if (illegal_set) begin
                illegal_op <= 1'b1;
            end
        end
    end

    alu_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (rs),
        .rb_addr  (rt),
        .dbg_addr (dbg_addr),
        .ra_data  (rs_data),
        .rb_data  (rt_data),
        .dbg_data (dbg_data),
        .we       (wb_en),
        .wa       (rd_q),
        .wd       (alu_result)
    );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a queue-based
// scoreboard for write-back and redirect events.
module tb_alu_issue_ctrl;

    localparam int DATA_W = 16;
    localparam int PC_W   = 8;
    localparam int IMM_W  = 4;

    logic              clk;
    logic              rst;
    logic              instr_valid;
    logic [15:0]       instr;
    logic              instr_ready;
    logic [3:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a, alu_b, alu_imm;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              wb_valid;
    logic              pc_redirect;
    logic [PC_W-1:0]   pc_target;
    logic              zero_flag;
    logic              illegal_op;
    logic [3:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;

    // Entry: [17] kind (0 write-back, 1 redirect), [16] zero flag, [15:0] value/target.
    logic [17:0] exp_q[$];

    alu_issue_ctrl #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .IMM_W  (IMM_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_imm     (alu_imm),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .wb_valid    (wb_valid),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .zero_flag   (zero_flag),
        .illegal_op  (illegal_op),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural ALU (registered result) ----------------
    always @(posedge clk) begin
        if (rst) begin
            alu_result <= '0;
            alu_zero   <= 1'b0;
        end else begin
            case (alu_opcode)
                4'b0010: begin alu_result <= alu_a + alu_b;   alu_zero <= 1'b0; end
                4'b0011: begin alu_result <= alu_a - alu_b;   alu_zero <= ((alu_a - alu_b) == '0); end
                4'b1010: begin alu_result <= alu_a + alu_imm; alu_zero <= 1'b0; end
                4'b1011: begin alu_result <= alu_a - alu_imm; alu_zero <= ((alu_a - alu_imm) == '0); end
                default: ;
            endcase
        end
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- accept counter ----------------
    initial forever begin
        @(posedge clk);
        if (instr_valid && instr_ready) n_acc++;
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        logic [17:0] e;
        @(negedge clk);
        if (wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_kind", 32'd0, {31'd0, e[17]});
                chk("wb_zero_flag", {31'd0, zero_flag}, {31'd0, e[16]});
                chk("wb_rf_value", {16'd0, dbg_data}, {16'd0, e[15:0]});
            end
        end
        if (pc_redirect) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_redirect", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("redir_kind", 32'd1, {31'd0, e[17]});
                chk("redir_target", {24'd0, pc_target}, {24'd0, e[7:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt);
        return {op, rd, rs, rt};
    endfunction

    // Called at a negedge; returns #1 after the accepting posedge.
    task automatic issue(input logic [15:0] ins);
        int t;
        t = 0;
        while (!instr_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'($urandom_range(0, 16'hFFFF));
    endtask

    // Issue an ALU op, expect its write-back exactly two edges after accept.
    task automatic alu_op(input string name, input logic [15:0] ins,
                          input logic [15:0] exp_val, input logic exp_zf);
        dbg_addr = ins[11:8];
        exp_q.push_back({1'b0, exp_zf, exp_val});
        issue(ins);
        @(negedge clk);
        chk({name, "_ready_exec"}, {31'd0, instr_ready}, 32'd0);
        chk({name, "_wb_early"}, {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        chk({name, "_ready_wb"}, {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        chk({name, "_wb_pulse"}, {31'd0, wb_valid}, 32'd1);
        chk({name, "_ready_back"}, {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic bz_op(input string name, input logic [7:0] tgt, input logic taken);
        if (taken) exp_q.push_back({1'b1, 1'b0, 8'd0, tgt});
        issue(enc(4'b0101, 4'd0, tgt[7:4], tgt[3:0]));
        @(negedge clk);
        chk({name, "_ready_br"}, {31'd0, instr_ready}, 32'd0);
        chk({name, "_redir_early"}, {31'd0, pc_redirect}, 32'd0);
        @(negedge clk);
        chk({name, "_redir"}, {31'd0, pc_redirect}, {31'd0, taken});
        chk({name, "_ready_back"}, {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic chk_reg(input string name, input logic [3:0] r, input logic [15:0] v);
        dbg_addr = r;
        #1;
        chk(name, {16'd0, dbg_data}, {16'd0, v});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] pw;
        int acc0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 4'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", {31'd0, instr_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_ready", {31'd0, instr_ready}, 32'd1);
        chk("reset_outputs", {alu_opcode, wb_valid, pc_redirect, pc_target, zero_flag, illegal_op},
            32'd0);
        chk("reset_alu_ab", {alu_a, alu_b}, 32'd0);
        chk("reset_alu_imm", {16'd0, alu_imm}, 32'd0);
        for (int i = 0; i < 16; i++) chk_reg("reset_rf", 4'(i), 16'h0000);
        @(negedge clk);

        alu_op("addi_r1", enc(4'b1010, 4'd1, 4'd0, 4'd5), 16'h0005, 1'b0);
        alu_op("addi_r2", enc(4'b1010, 4'd2, 4'd0, 4'hD), 16'hFFFD, 1'b0);
        alu_op("sub_r3",  enc(4'b0011, 4'd3, 4'd1, 4'd1), 16'h0000, 1'b1);
        bz_op("bz_taken", 8'h40, 1'b1);
        chk("zf_after_bz", {31'd0, zero_flag}, 32'd1);
        alu_op("add_r4",  enc(4'b0010, 4'd4, 4'd1, 4'd2), 16'h0002, 1'b0);
        bz_op("bz_not_taken", 8'h40, 1'b0);
        alu_op("subi_r10", enc(4'b1011, 4'd10, 4'd1, 4'd5), 16'h0000, 1'b1);
        alu_op("sub_r13",  enc(4'b0011, 4'd13, 4'd2, 4'd1), 16'hFFF8, 1'b0);

        alu_op("addi_r7", enc(4'b1010, 4'd7, 4'd0, 4'd1), 16'h0001, 1'b0);
        for (int k = 1; k < 16; k++) begin
            pw = 16'd1 << k;
            alu_op("dbl_r7", enc(4'b0010, 4'd7, 4'd7, 4'd7), pw, 1'b0);
        end
        alu_op("subi_r8", enc(4'b1011, 4'd8, 4'd7, 4'd1), 16'h7FFF, 1'b0);
        alu_op("addi_wrap_r9", enc(4'b1010, 4'd9, 4'd8, 4'd1), 16'h8000, 1'b0);
        alu_op("add_wrap_r14", enc(4'b0010, 4'd14, 4'd9, 4'd9), 16'h0000, 1'b0);

        alu_op("addi_r0", enc(4'b1010, 4'd0, 4'd0, 4'd7), 16'h0000, 1'b0);

        issue(enc(4'b1111, 4'd1, 4'd2, 4'd3));
        @(negedge clk);
        chk("illegal_set", {31'd0, illegal_op}, 32'd1);
        chk("illegal_ready", {31'd0, instr_ready}, 32'd1);
        chk("illegal_no_wb", {31'd0, wb_valid}, 32'd0);
        chk_reg("illegal_r1_kept", 4'd1, 16'h0005);
        alu_op("sub_r15", enc(4'b0011, 4'd15, 4'd4, 4'd1), 16'hFFFD, 1'b0);
        chk("illegal_sticky", {31'd0, illegal_op}, 32'd1);

        // valid held (and instr changed) while busy: exactly one accept
        dbg_addr = 4'd11;
        acc0 = n_acc;
        exp_q.push_back({1'b0, 1'b0, 16'h0003});
        instr_valid = 1'b1;
        instr       = enc(4'b1010, 4'd11, 4'd0, 4'd3);
        @(posedge clk);
        #1;
        instr = enc(4'b1010, 4'd12, 4'd0, 4'd7);
        @(posedge clk);
        #1;
        instr = enc(4'b1111, 4'd12, 4'd0, 4'd0);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("held_accept_count", n_acc - acc0, 32'd1);
        chk("held_wb_pulse", {31'd0, wb_valid}, 32'd1);
        chk_reg("held_r12_untouched", 4'd12, 16'h0000);
        @(negedge clk);

        // reset during EXEC aborts the write-back
        dbg_addr = 4'd5;
        issue(enc(4'b1010, 4'd5, 4'd0, 4'd1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready_in_rst", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_wb", {31'd0, wb_valid}, 32'd0);
            @(negedge clk);
        end
        chk_reg("abort_r5", 4'd5, 16'h0000);
        chk_reg("abort_r1_cleared", 4'd1, 16'h0000);
        chk("abort_flags", {alu_opcode, zero_flag, illegal_op, pc_redirect}, 32'd0);
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
